// File: rtl/core_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_sequencer_if
//
// Purpose: the single shared memory bus of the furv core. The sequencer is
// the only requester on it and uses it for both instruction fetch and
// load/store data accesses.
//
// Signals:
//   bus_req       requester -> memory  a memory request is outstanding
//   bus_we        requester -> memory  the request is a write
//   bus_addr_sel  requester -> memory  address source: 0 = PC, 1 = ALU result
//   bus_ack       memory -> requester  memory completes the request this cycle
//
// Modports:
//   master  the sequencer side (drives request, samples ack)
//   slave   the memory side (samples request, drives ack)
// ---------------------------------------------------------------------------
interface core_sequencer_if;

   logic bus_req;
   logic bus_we;
   logic bus_addr_sel;
   logic bus_ack;

   // The sequencer owns the request lines and listens for completion.
   modport master (
      output bus_req,
      output bus_we,
      output bus_addr_sel,
      input  bus_ack
   );

   // Memory watches the request lines and answers with an ack.
   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr_sel,
      output bus_ack
   );

endinterface

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//
// Purpose: multi-cycle control FSM of the furv core. Each instruction walks
// through FETCH, DECODE, EXEC, an optional MEM and WB. The single memory bus
// is time-shared between instruction fetch (address from PC) and load/store
// (address from the ALU). The block only issues write strobes and bus
// requests; it never touches datapath values.
//
// Parameters:
//   TIMEOUT_CYCLES  wait cycles a bus request may sit unanswered before a
//                   fault is raised (1..65535)
//   COUNT_W         width of the retired-instruction counter
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   bus             memory bus (master side): bus_req/bus_we/bus_addr_sel out,
//                   bus_ack in
//   i_insn_valid    decoder saw a legal opcode (looked at in DECODE)
//   i_mem           instruction is a load or store
//   i_mem_write     the memory access is a store
//   i_branch        conditional branch
//   i_jump          unconditional transfer (JAL/JALR)
//   i_branch_taken  ALU compare result (looked at in WB)
//   i_rd_zero       destination register is x0
//   i_halt_req      debug stop request, honoured at instruction boundaries
//   o_ir_we         latch fetched word into IR
//   o_mdr_we        latch load data into MDR
//   o_rf_we         register-file write
//   o_pc_we         PC update
//   o_pc_sel        next-PC source: 0 = PC+4, 1 = ALU target
//   o_halted        FSM sits in HALT
//   o_fault         FSM sits in FAULT (sticky until reset)
//   o_fault_cause   01 fetch timeout, 10 data timeout, 11 illegal instruction
//   o_state         current state encoding, for debug
//   o_instret       retired-instruction count, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module core_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned COUNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst,
   core_sequencer_if.master    bus,
   input  logic                i_insn_valid,
   input  logic                i_mem,
   input  logic                i_mem_write,
   input  logic                i_branch,
   input  logic                i_jump,
   input  logic                i_branch_taken,
   input  logic                i_rd_zero,
   input  logic                i_halt_req,
   output logic                o_ir_we,
   output logic                o_mdr_we,
   output logic                o_rf_we,
   output logic                o_pc_we,
   output logic                o_pc_sel,
   output logic                o_halted,
   output logic                o_fault,
   output logic [1:0]          o_fault_cause,
   output logic [2:0]          o_state,
   output logic [COUNT_W-1:0]  o_instret
);

   // State encodings are visible on o_state, so they are pinned explicitly.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   // Fault reason codes as seen on o_fault_cause.
   localparam logic [1:0] LP_CAUSE_FETCH   = 2'b01;
   localparam logic [1:0] LP_CAUSE_DATA    = 2'b10;
   localparam logic [1:0] LP_CAUSE_ILLEGAL = 2'b11;

   // The wait counter is 16 bits wide, which covers the whole legal range
   // of the timeout limit.
   localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

   state_t              r_state;
   logic [15:0]         r_wait;
   logic [1:0]          r_cause;
   logic [COUNT_W-1:0]  r_instret;

   // A bus wait cycle is one where we are asking and memory has not
   // answered. The limit check only matters in those cycles: an ack in the
   // very cycle the count hits the limit still completes the access.
   logic w_wait_cycle;
   logic w_timed_out;

   assign w_wait_cycle = bus.bus_req & ~bus.bus_ack;
   assign w_timed_out  = w_wait_cycle & (r_wait == LP_TIMEOUT);

   // -----------------------------------------------------------------------
   // Sequencing FSM. All architectural state of the block lives here:
   // current state, bus wait counter, sticky fault cause and the retired
   // instruction counter. The wait counter is cleared whenever we move into
   // FETCH or MEM so every bus access gets the full timeout budget, and it
   // only advances while a request is left unanswered. Because reaching the
   // limit without an ack always leaves the bus state, the counter can never
   // run past TIMEOUT_CYCLES. FAULT is a trap: only reset gets us out.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_wait    <= 16'd0;
         r_cause   <= 2'b00;
         r_instret <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (bus.bus_ack) begin
                  r_state <= S_DECODE;
                  r_wait  <= 16'd0;
               end else if (w_timed_out) begin
                  r_state <= S_FAULT;
                  r_cause <= LP_CAUSE_FETCH;
               end else if (w_wait_cycle) begin
                  r_wait <= r_wait + 16'd1;
               end
            end

            S_DECODE: begin
               if (!i_insn_valid) begin
                  r_state <= S_FAULT;
                  r_cause <= LP_CAUSE_ILLEGAL;
               end else begin
                  r_state <= S_EXEC;
               end
            end

            S_EXEC: begin
               if (i_mem) begin
                  r_state <= S_MEM;
                  r_wait  <= 16'd0;
               end else begin
                  r_state <= S_WB;
               end
            end

            S_MEM: begin
               if (bus.bus_ack) begin
                  r_state <= S_WB;
                  r_wait  <= 16'd0;
               end else if (w_timed_out) begin
                  r_state <= S_FAULT;
                  r_cause <= LP_CAUSE_DATA;
               end else if (w_wait_cycle) begin
                  r_wait <= r_wait + 16'd1;
               end
            end

            S_WB: begin
               // Retirement point. The halt request is only honoured here
               // and in HALT, so a stop never cuts an instruction short.
               r_instret <= r_instret + COUNT_W'(1);
               r_wait    <= 16'd0;
               if (i_halt_req) begin
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_FETCH;
               end
            end

            S_HALT: begin
               if (!i_halt_req) begin
                  r_state <= S_FETCH;
                  r_wait  <= 16'd0;
               end
            end

            S_FAULT: begin
               r_state <= S_FAULT;
            end

            default: begin
               // The spare encoding is unreachable; fall back to a clean
               // instruction boundary if it ever shows up.
               r_state <= S_FETCH;
               r_wait  <= 16'd0;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Strobe and bus-request decode. These are combinational from the current
   // state and the live inputs so a zero-wait ack can complete in the same
   // cycle it arrives. Only ir_we and mdr_we look at bus_ack. Everything is
   // forced low while reset is held, which drops an in-flight request the
   // moment reset asserts instead of waiting for a clock edge. FAULT, HALT,
   // DECODE and EXEC fall into the all-zero default.
   // -----------------------------------------------------------------------
   always_comb begin
      bus.bus_req      = 1'b0;
      bus.bus_we       = 1'b0;
      bus.bus_addr_sel = 1'b0;
      o_ir_we          = 1'b0;
      o_mdr_we         = 1'b0;
      o_rf_we          = 1'b0;
      o_pc_we          = 1'b0;
      o_pc_sel         = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               bus.bus_req = 1'b1;
               o_ir_we     = bus.bus_ack;
            end

            S_MEM: begin
               bus.bus_req      = 1'b1;
               bus.bus_we       = i_mem_write;
               bus.bus_addr_sel = 1'b1;
               o_mdr_we         = bus.bus_ack & ~i_mem_write;
            end

            S_WB: begin
               // Branches and stores produce no register result, and x0
               // writes are suppressed here rather than in the register file.
               o_rf_we  = ~i_rd_zero & ~i_branch & ~(i_mem & i_mem_write);
               o_pc_we  = 1'b1;
               o_pc_sel = i_jump | (i_branch & i_branch_taken);
            end

            default: begin
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Status outputs come straight from registered state, so fault and halted
   // line up with the cycle o_state shows FAULT or HALT.
   // -----------------------------------------------------------------------
   assign o_state       = r_state;
   assign o_halted      = (r_state == S_HALT);
   assign o_fault       = (r_state == S_FAULT);
   assign o_fault_cause = r_cause;
   assign o_instret     = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
//
// Purpose: self-checking bench for core_sequencer. Instructions are described
// at the transaction level (kind, ack delays, halt length) and expanded into
// an expected per-cycle trace of inputs and outputs, which is then played
// against the DUT cycle by cycle.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

   localparam int TO = 4;
   localparam int CW = 8;

   typedef struct {
      logic          rst;
      logic          ack;
      logic          valid;
      logic          mem;
      logic          mw;
      logic          br;
      logic          jmp;
      logic          tk;
      logic          rdz;
      logic          hreq;
      logic [2:0]    st;
      logic          req;
      logic          we;
      logic          asel;
      logic          irwe;
      logic          mdrwe;
      logic          rfwe;
      logic          pcwe;
      logic          pcsel;
      logic          halted;
      logic          fault;
      logic [1:0]    cause;
      logic [CW-1:0] instret;
   } cyc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic insnValid = 1'b0;
   logic memI = 1'b0;
   logic memWrite = 1'b0;
   logic branchI = 1'b0;
   logic jumpI = 1'b0;
   logic branchTaken = 1'b0;
   logic rdZero = 1'b0;
   logic haltReq = 1'b0;

   logic          irWe, mdrWe, rfWe, pcWe, pcSel, haltedO, faultO;
   logic [1:0]    faultCause;
   logic [2:0]    stateO;
   logic [CW-1:0] instretO;

   core_sequencer_if busIf ();

   core_sequencer #(
      .TIMEOUT_CYCLES(TO),
      .COUNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(busIf.master),
      .i_insn_valid(insnValid),
      .i_mem(memI),
      .i_mem_write(memWrite),
      .i_branch(branchI),
      .i_jump(jumpI),
      .i_branch_taken(branchTaken),
      .i_rd_zero(rdZero),
      .i_halt_req(haltReq),
      .o_ir_we(irWe),
      .o_mdr_we(mdrWe),
      .o_rf_we(rfWe),
      .o_pc_we(pcWe),
      .o_pc_sel(pcSel),
      .o_halted(haltedO),
      .o_fault(faultO),
      .o_fault_cause(faultCause),
      .o_state(stateO),
      .o_instret(instretO)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int   checks = 0;
   int   passes = 0;
   int   cycNum = 0;
   int   mInstret = 0;
   cyc_t q[$];
   cyc_t e;

   // Current instruction description used while expanding a trace.
   logic curValid, curMem, curMw, curBr, curJmp, curTk, curRdz;
   logic forceHaltExec = 1'b0;

   // One comparison: count it, report it if it disagrees.
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycNum, act, exp);
      end else begin
         passes++;
      end
   endtask

   // Literal expectations on the model trace itself.
   task automatic checkVal(input string name, input int act, input int exp);
      cmp(name, 32'(act), 32'(exp));
   endtask

   // Start a fresh expected cycle in the given state, with no strobes and
   // don't-care inputs randomised.
   task automatic newCyc(input logic [2:0] st);
      e = '{default: '0};
      e.valid   = curValid;
      e.mem     = curMem;
      e.mw      = curMw;
      e.br      = curBr;
      e.jmp     = curJmp;
      e.tk      = curTk;
      e.rdz     = curRdz;
      e.ack     = 1'($urandom % 2);
      e.hreq    = 1'($urandom % 2);
      e.st      = st;
      e.instret = CW'(mInstret);
   endtask

   task automatic pushReset();
      newCyc(3'd0);
      e.rst     = 1'b1;
      mInstret  = 0;
      e.instret = '0;
      q.push_back(e);
   endtask

   // FAULT is sticky: a few cycles with random acks, then a reset.
   task automatic pushFault(input logic [1:0] cause);
      for (int i = 0; i < 3; i++) begin
         newCyc(3'd6);
         e.fault = 1'b1;
         e.cause = cause;
         q.push_back(e);
      end
      pushReset();
   endtask

   // Expand one instruction. df/dm are ack delays in wait cycles, a value
   // above TO means memory never answers. hk<0 means no halt, otherwise the
   // number of extra HALT cycles with halt_req still high. cutMem>=0 asserts
   // reset after that many unanswered MEM cycles.
   task automatic pushInsn(input int df, input int dm, input int hk, input int cutMem);
      int nf, nm;
      nf = (df > TO) ? TO + 1 : df + 1;
      for (int i = 0; i < nf; i++) begin
         newCyc(3'd0);
         e.req  = 1'b1;
         e.ack  = (df <= TO) && (i == df);
         e.irwe = e.ack;
         q.push_back(e);
      end
      if (df > TO) begin
         pushFault(2'b01);
         return;
      end
      newCyc(3'd1);
      q.push_back(e);
      if (!curValid) begin
         pushFault(2'b11);
         return;
      end
      newCyc(3'd2);
      if (forceHaltExec) e.hreq = 1'b1;
      q.push_back(e);
      if (curMem) begin
         nm = (cutMem >= 0) ? cutMem : ((dm > TO) ? TO + 1 : dm + 1);
         for (int i = 0; i < nm; i++) begin
            newCyc(3'd3);
            e.req   = 1'b1;
            e.we    = curMw;
            e.asel  = 1'b1;
            e.ack   = (cutMem < 0) && (dm <= TO) && (i == dm);
            e.mdrwe = e.ack & ~curMw;
            q.push_back(e);
         end
         if (cutMem >= 0) begin
            pushReset();
            return;
         end
         if (dm > TO) begin
            pushFault(2'b10);
            return;
         end
      end
      newCyc(3'd4);
      e.rfwe  = ~curRdz & ~curBr & ~(curMem & curMw);
      e.pcwe  = 1'b1;
      e.pcsel = curJmp | (curBr & curTk);
      e.hreq  = (hk >= 0);
      q.push_back(e);
      mInstret = (mInstret + 1) % (1 << CW);
      for (int j = 0; j <= hk; j++) begin
         newCyc(3'd5);
         e.halted = 1'b1;
         e.hreq   = (j < hk);
         q.push_back(e);
      end
   endtask

   task automatic setInsn(input logic v, input logic m, input logic w, input logic b,
                          input logic j, input logic t, input logic z);
      curValid = v; curMem = m; curMw = w; curBr = b; curJmp = j; curTk = t; curRdz = z;
   endtask

   task automatic randInsn();
      setInsn(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 4 == 0),
              1'($urandom % 5 == 0), 1'($urandom % 2), 1'($urandom % 6 == 0));
   endtask

   function automatic int randDelay();
      return ($urandom % 3 == 0) ? int'($urandom_range(0, TO)) : 0;
   endfunction

   function automatic int randHalt();
      return ($urandom % 8 == 0) ? int'($urandom_range(0, 3)) : -1;
   endfunction

   task automatic applyStimulus(input cyc_t c);
      rst            = c.rst;
      busIf.bus_ack  = c.ack;
      insnValid      = c.valid;
      memI           = c.mem;
      memWrite       = c.mw;
      branchI        = c.br;
      jumpI          = c.jmp;
      branchTaken    = c.tk;
      rdZero         = c.rdz;
      haltReq        = c.hreq;
   endtask

   task automatic checkOutput(input cyc_t c);
      cmp("state",        32'(stateO),             32'(c.st));
      cmp("bus_req",      32'(busIf.bus_req),      32'(c.req));
      cmp("bus_we",       32'(busIf.bus_we),       32'(c.we));
      cmp("bus_addr_sel", 32'(busIf.bus_addr_sel), 32'(c.asel));
      cmp("ir_we",        32'(irWe),               32'(c.irwe));
      cmp("mdr_we",       32'(mdrWe),              32'(c.mdrwe));
      cmp("rf_we",        32'(rfWe),               32'(c.rfwe));
      cmp("pc_we",        32'(pcWe),               32'(c.pcwe));
      cmp("pc_sel",       32'(pcSel),              32'(c.pcsel));
      cmp("halted",       32'(haltedO),            32'(c.halted));
      cmp("fault",        32'(faultO),             32'(c.fault));
      cmp("fault_cause",  32'(faultCause),         32'(c.cause));
      cmp("instret",      32'(instretO),           32'(c.instret));
   endtask

   // Play the expected trace: drive just after the rising edge, compare on
   // the falling edge.
   task automatic runQueue();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         applyStimulus(c);
         @(negedge clk);
         checkOutput(c);
         cycNum++;
      end
   endtask

   initial begin
      busIf.bus_ack = 1'b0;
      setInsn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Zero-wait ALU instruction straight out of reset.
      pushReset();
      setInsn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushInsn(0, 0, -1, -1);
      checkVal("model_alu_len", q.size(), 5);
      checkVal("model_alu_seq", int'({q[1].st, q[2].st, q[3].st, q[4].st}), 12'h054);
      checkVal("model_alu_rfwe", int'(q[4].rfwe), 1);
      checkVal("model_alu_pcsel", int'(q[4].pcsel), 0);
      checkVal("model_alu_instret", mInstret, 1);
      runQueue();

      // Load with a three-cycle data wait.
      setInsn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushInsn(0, 3, -1, -1);
      checkVal("model_load_len", q.size(), 8);
      checkVal("model_load_mdr", int'(q[6].mdrwe), 1);
      runQueue();

      // Store then taken branch.
      setInsn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pushInsn(0, 0, -1, -1);
      checkVal("model_store_rfwe", int'(q[4].rfwe), 0);
      setInsn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      pushInsn(1, 0, -1, -1);
      runQueue();

      // Halt requested during EXEC, held one extra HALT cycle.
      forceHaltExec = 1'b1;
      setInsn(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      pushInsn(0, 0, 1, -1);
      forceHaltExec = 1'b0;
      runQueue();

      // Reset in the middle of a data wait, with instructions retired.
      setInsn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushInsn(0, 0, -1, 2);
      runQueue();

      // Fetch never acknowledged.
      pushInsn(TO + 1, 0, -1, -1);
      checkVal("model_to_len", q.size(), TO + 5);
      checkVal("model_to_cause", int'(q[TO + 1].cause), 1);
      runQueue();

      // Illegal instruction.
      setInsn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pushInsn(0, 0, -1, -1);
      runQueue();

      // Long unbroken run so the counter wraps.
      for (int n = 0; n < 260; n++) begin
         randInsn();
         pushInsn(randDelay(), randDelay(), randHalt(), -1);
         runQueue();
      end

      // Mixed run including faults and resets.
      for (int n = 0; n < 150; n++) begin
         int r;
         r = int'($urandom % 20);
         randInsn();
         case (r)
            0: pushInsn(TO + 1, 0, -1, -1);
            1: begin curMem = 1'b1; pushInsn(randDelay(), TO + 1, -1, -1); end
            2: begin curValid = 1'b0; pushInsn(randDelay(), 0, -1, -1); end
            3: begin curMem = 1'b1; pushInsn(0, 0, -1, int'($urandom_range(0, TO))); end
            default: pushInsn(randDelay(), randDelay(), randHalt(), -1);
         endcase
         runQueue();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
